// File: rtl/demux_pkg.sv
// Shared sizing constants and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;
    localparam int CNTW = 16;

    function automatic logic [SELW-1:0] ptr_next(input logic [SELW-1:0] p);
        return p + SELW'(1);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel register: holds a word until its consumer takes it.
module demux_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // A load wins over a drain so a full slot can be refilled every cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/demux1to4_stream.sv
// Steers a valid/ready input stream to one of four registered output channels,
// chosen by an explicit select or by a round-robin pointer.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SELW-1:0]   in_sel,
    input  logic              rr_en,
    output logic [SELW-1:0]   rr_ptr,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [CNTW-1:0]   acc_cnt
);

    logic [SELW-1:0] tgt;
    logic            accept;
    logic [NCH-1:0]  load;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] acc_cnt_q, acc_cnt_d;

    // in_ready looks only at the targeted slot, never at in_valid.
    always_comb begin
        tgt      = rr_en ? rr_ptr_q : in_sel;
        in_ready = !out_valid[tgt] || out_ready[tgt];
        accept   = in_valid && in_ready;
        load     = '0;
        for (int i = 0; i < NCH; i++) begin
            load[i] = accept && (tgt == SELW'(i));
        end
        rr_ptr_d  = (accept && rr_en) ? ptr_next(rr_ptr_q) : rr_ptr_q;
        acc_cnt_d = accept ? acc_cnt_q + CNTW'(1) : acc_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign rr_ptr  = rr_ptr_q;
    assign acc_cnt = acc_cnt_q;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DW +: DW])
        );
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Scoreboard bench for demux1to4_stream: per-channel expected-word queues.
module tb_demux1to4_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          rr_en;
    logic [1:0]    rr_ptr;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*DW-1:0] out_data;
    logic [15:0]   acc_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sbq[4][$];
    logic [1:0]    m_ptr;
    logic [15:0]   m_cnt;

    demux1to4_stream #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .rr_en     (rr_en),
        .rr_ptr    (rr_ptr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: inputs are stable mid-cycle, so what is seen here is what the next edge acts on.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [1:0]    t;
            logic          exp_rdy;
            logic [DW-1:0] exp_d;
            t       = rr_en ? m_ptr : in_sel;
            exp_rdy = (sbq[t].size() == 0) || out_ready[t];
            chk("rr_ptr", rr_ptr, m_ptr);
            chk("acc_cnt", acc_cnt, m_cnt);
            chk("in_ready", in_ready, exp_rdy);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid%0d", i), out_valid[i], sbq[i].size() != 0);
                if (out_ready[i] && sbq[i].size() != 0) begin
                    exp_d = sbq[i].pop_front();
                    chk($sformatf("out_data%0d", i), out_data[i*DW +: DW], exp_d);
                end
            end
            if (in_valid && exp_rdy) begin
                sbq[t].push_back(in_data);
                m_cnt = m_cnt + 16'd1;
                if (rr_en) m_ptr = m_ptr + 2'd1;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [1:0] s);
        int   n;
        logic rdy;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 20) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) sbq[i].delete();
        m_ptr = 2'd0;
        m_cnt = 16'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        rr_en     = 1'b0;
        out_ready = 4'hF;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_acc_cnt", acc_cnt, 16'd0);
        chk("rst_rr_ptr", rr_ptr, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Explicit select, all consumers ready.
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 2'(i));
        @(negedge clk);
        chk("acc_after_sel", acc_cnt, 16'd4);
        idle(2);

        // Round robin, six words from pointer 0.
        rr_en = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 2'd0);
        @(negedge clk);
        chk("rr_ptr_end", rr_ptr, 2'd2);
        chk("acc_after_rr", acc_cnt, 16'd10);
        rr_en = 1'b0;
        idle(2);

        // Back-pressure on channel 2, then release with no bubble.
        out_ready[2] = 1'b0;
        send(8'h55, 2'd2);
        fork
            send(8'h66, 2'd2);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("blocked_in_ready", in_ready, 1'b0);
                    chk("held_data2", out_data[2*DW +: DW], 8'h55);
                end
                @(posedge clk);
                #1;
                out_ready[2] = 1'b1;
            end
        join
        idle(3);

        // Channel 1 blocked does not stall traffic to channel 3.
        out_ready[1] = 1'b0;
        send(8'h31, 2'd1);
        send(8'h77, 2'd3);
        @(negedge clk);
        chk("ch1_still_valid", out_valid[1], 1'b1);
        chk("ch1_data_kept", out_data[1*DW +: DW], 8'h31);
        out_ready[1] = 1'b1;
        idle(3);

        // Round-robin stall on a full, blocked target.
        out_ready[rr_ptr] = 1'b0;
        send(8'h88, rr_ptr);
        rr_en    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        begin
            logic [1:0]  p0;
            logic [15:0] c0;
            p0 = rr_ptr;
            c0 = acc_cnt;
            repeat (3) begin
                @(negedge clk);
                chk("stall_ptr", rr_ptr, p0);
                chk("stall_cnt", acc_cnt, c0);
                chk("stall_ready", in_ready, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rr_en     = 1'b0;
        out_ready = 4'hF;
        idle(3);

        // Asynchronous reset mid-transfer with two full slots.
        out_ready = 4'b1100;
        send(8'hC0, 2'd0);
        send(8'hC1, 2'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_cnt", acc_cnt, 16'd0);
        chk("mid_rst_ptr", rr_ptr, 2'd0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 4'hF;
        send(8'hD0, 2'd0);
        @(negedge clk);
        chk("post_rst_cnt", acc_cnt, 16'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
